// File: rtl/dma_sched_pkg.sv
// -----------------------------------------------------------------------------
// dma_sched_pkg
// Shared types and default widths for the DMA descriptor scheduler and the
// system top that hosts dma_controller_module.
//   DMA_ADDR_W / DMA_SIZE_W : default address / byte-count widths
//   sched_state_t           : scheduler FSM encoding
//   desc_t                  : descriptor (addr, size) at the default widths
// -----------------------------------------------------------------------------
package dma_sched_pkg;

    localparam int DMA_ADDR_W = 8;
    localparam int DMA_SIZE_W = 8;
    localparam int DMA_CNT_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_RELEASE   = 3'd3,
        S_HALT      = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] addr;
        logic [DMA_SIZE_W-1:0] size;
    } desc_t;

endpackage

// File: rtl/dma_desc_fifo.sv
// -----------------------------------------------------------------------------
// dma_desc_fifo
// Synchronous circular-buffer FIFO of descriptor entries.
//   clk, rstn        : clock, async active-low reset (pointers/count only)
//   push_i, din_i    : write request and entry; ignored while full
//   pop_i, dout_o    : read request; dout_o is the current head (show-ahead)
//   full_o, empty_o  : occupancy flags derived from the registered count
//   count_o          : number of stored entries
// -----------------------------------------------------------------------------
module dma_desc_fifo
    import dma_sched_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = desc_t
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push_i,
    input  entry_t                     din_i,
    input  logic                       pop_i,
    output entry_t                     dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/dma_descriptor_scheduler.sv
// -----------------------------------------------------------------------------
// dma_descriptor_scheduler
// Queues CPU descriptors and issues them one at a time to the DMA controller
// using its level start / level done handshake. Zero-length descriptors are
// retired without launching; each launch is guarded by a timeout that parks
// the scheduler in HALT until software clears the error.
//   clk, rstn                          : clock, async active-low reset
//   desc_valid/desc_ready/addr/size    : CPU descriptor push interface
//   dma_start, dma_start_address,
//   dma_transfer_size, dma_done        : controller handshake
//   err_clear                          : leave HALT, clear timeout_err
//   busy, queue_count, completed_count,
//   done_pulse, timeout_err            : status
// -----------------------------------------------------------------------------
module dma_descriptor_scheduler
    import dma_sched_pkg::*;
#(
    parameter int ADDR_WIDTH     = DMA_ADDR_W,
    parameter int SIZE_WIDTH     = DMA_SIZE_W,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = DMA_CNT_W
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             desc_valid,
    output logic                             desc_ready,
    input  logic [ADDR_WIDTH-1:0]            desc_addr,
    input  logic [SIZE_WIDTH-1:0]            desc_size,
    output logic                             dma_start,
    output logic [ADDR_WIDTH-1:0]            dma_start_address,
    output logic [SIZE_WIDTH-1:0]            dma_transfer_size,
    input  logic                             dma_done,
    input  logic                             err_clear,
    output logic                             busy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
    output logic [CNT_WIDTH-1:0]             completed_count,
    output logic                             done_pulse,
    output logic                             timeout_err
);

    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [SIZE_WIDTH-1:0] size;
    } entry_t;

    entry_t head, push_entry;
    logic   fifo_full, fifo_empty, pop;

    sched_state_t          state_q, state_d;
    logic                  start_q, start_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d;
    logic [TCW-1:0]        tcnt_q, tcnt_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  cmp_q, cmp_d;
    logic                  pulse_q, pulse_d;

    assign push_entry = '{addr: desc_addr, size: desc_size};

    dma_desc_fifo #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (desc_valid),
        .din_i   (push_entry),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (queue_count)
    );

    // Ready follows the registered occupancy only, so a pop in the same
    // cycle never opens a slot early.
    assign desc_ready        = !fifo_full;
    assign dma_start         = start_q;
    assign dma_start_address = addr_q;
    assign dma_transfer_size = size_q;
    assign busy              = (state_q != S_IDLE) || !fifo_empty;
    assign completed_count   = cmp_q;
    assign done_pulse        = pulse_q;
    assign timeout_err       = err_q;

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        addr_d  = addr_q;
        size_d  = size_q;
        tcnt_d  = tcnt_q;
        err_d   = err_q;
        cmp_d   = cmp_q;
        pulse_d = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head.size == '0) begin
                        // Retire empty descriptor without touching the controller.
                        pulse_d = 1'b1;
                        cmp_d   = cmp_q + 1'b1;
                    end else begin
                        addr_d  = head.addr;
                        size_d  = head.size;
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                start_d = 1'b1;
                tcnt_d  = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (dma_done) begin
                    start_d = 1'b0;
                    state_d = S_RELEASE;
                end else if (tcnt_q == TC_LAST) begin
                    err_d   = 1'b1;
                    start_d = 1'b0;
                    state_d = S_HALT;
                end else if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                // Controller drops done only after it sees start low.
                start_d = 1'b0;
                if (!dma_done) begin
                    pulse_d = 1'b1;
                    cmp_d   = cmp_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                start_d = 1'b0;
                if (err_clear) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            cmp_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            cmp_q   <= cmp_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: tb/tb_dma_descriptor_scheduler.sv
module tb_dma_descriptor_scheduler;

    localparam int AW = 8;
    localparam int SW = 8;
    localparam int QD = 4;
    localparam int TO = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          desc_valid;
    logic          desc_ready;
    logic [AW-1:0] desc_addr;
    logic [SW-1:0] desc_size;
    logic          dma_start;
    logic [AW-1:0] dma_start_address;
    logic [SW-1:0] dma_transfer_size;
    logic          dma_done;
    logic          err_clear;
    logic          busy;
    logic [2:0]    queue_count;
    logic [CW-1:0] completed_count;
    logic          done_pulse;
    logic          timeout_err;

    always #5 clk = ~clk;

    dma_descriptor_scheduler #(
        .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .QUEUE_DEPTH(QD),
        .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_addr(desc_addr), .desc_size(desc_size),
        .dma_start(dma_start), .dma_start_address(dma_start_address),
        .dma_transfer_size(dma_transfer_size), .dma_done(dma_done),
        .err_clear(err_clear), .busy(busy), .queue_count(queue_count),
        .completed_count(completed_count), .done_pulse(done_pulse),
        .timeout_err(timeout_err)
    );

    // ---------------- controller model: copies a source stream -------------
    logic       ctrl_en;
    logic [7:0] mem [256];
    logic [7:0] src_idx;
    logic [7:0] xfer_k;

    function automatic logic [7:0] src_byte(input logic [7:0] i);
        logic [127:0] s;
        s = "Advanced DMA tst";
        return s[127 - 8*int'(i[3:0]) -: 8];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dma_done <= 1'b0;
            xfer_k   <= '0;
            src_idx  <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (!dma_start) begin
            dma_done <= 1'b0;
            xfer_k   <= '0;
        end else if (ctrl_en && !dma_done) begin
            mem[8'(dma_start_address + xfer_k)] <= src_byte(src_idx);
            src_idx <= src_idx + 1'b1;
            xfer_k  <= xfer_k + 1'b1;
            if (xfer_k == dma_transfer_size - 1'b1) dma_done <= 1'b1;
        end
    end

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int n_rise = 0, n_pulse = 0, n_acc = 0;
    int rise_cyc = 0, drv_cyc = 0, peak = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] size;
    } sb_t;
    sb_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: each start rise must present the oldest non-empty descriptor.
    initial begin
        logic prev_start;
        sb_t  e;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && dma_start && !prev_start) begin
                n_rise++;
                rise_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("start_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("start_addr", dma_start_address, e.addr);
                    chk("start_size", dma_transfer_size, e.size);
                end
            end
            if (done_pulse) n_pulse++;
            if (int'(queue_count) > peak) peak = int'(queue_count);
            prev_start = dma_start;
        end
    end

    // Called at a negedge; the push edge is the next posedge.
    task automatic push(input logic [7:0] a, input logic [7:0] s);
        desc_valid = 1'b1;
        desc_addr  = a;
        desc_size  = s;
        if (desc_ready) begin
            n_acc++;
            drv_cyc = cyc;
            if (s != 0) sb.push_back('{a, s});
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || dma_start) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", (n >= budget), 0);
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        int         batch;
        logic [7:0] addr;
        logic [7:0] size;
        logic [31:0] exp;   // expected bytes, addr+0 in bits [7:0]
    } vec_t;
    vec_t vt[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, p0, hi, n, done_so_far, nb;
        vt[0] = '{0, 8'h10, 8'd4, 32'h61766441};
        vt[1] = '{1, 8'h20, 8'd2, 32'h0000636E};
        vt[2] = '{1, 8'h30, 8'd3, 32'h00206465};
        vt[3] = '{1, 8'h40, 8'd1, 32'h00000044};

        rstn = 1'b0; desc_valid = 1'b0; desc_addr = '0; desc_size = '0;
        err_clear = 1'b0; ctrl_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready",  desc_ready, 1);
        chk("rst_qcount", queue_count, 0);
        chk("rst_outs", {dma_start, dma_start_address, dma_transfer_size,
                         busy, completed_count, done_pulse, timeout_err}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // ---- table-driven: single descriptor, then back-to-back batch ----
        done_so_far = 0;
        for (int b = 0; b < 2; b++) begin
            r0 = n_rise; p0 = n_pulse; peak = 0; nb = 0;
            for (int i = 0; i < 4; i++)
                if (vt[i].batch == b) begin push(vt[i].addr, vt[i].size); nb++; end
            desc_valid = 1'b0;
            wait_idle(300);
            for (int i = 0; i < 4; i++)
                if (vt[i].batch == b)
                    for (int k = 0; k < int'(vt[i].size); k++)
                        chk("mem_byte", mem[8'(vt[i].addr + k)], vt[i].exp[8*k +: 8]);
            done_so_far += nb;
            chk("completed", completed_count, done_so_far);
            chk("start_rises", n_rise - r0, nb);
            chk("done_pulses", n_pulse - p0, nb);
            if (nb == 1) chk("start_latency", rise_cyc - (drv_cyc + 1), 2);
            else         chk("q_peak_2_or_3", (peak == 2 || peak == 3), 1);
        end

        // ---- full queue with done held low ----
        do_reset();
        ctrl_en = 1'b0; n_acc = 0;
        for (int i = 0; i < 6; i++) push(8'(8'h80 + 4*i), 8'd1);
        desc_valid = 1'b0;
        chk("full_accepted", n_acc, 5);
        chk("full_qcount", queue_count, 4);
        chk("full_ready", desc_ready, 0);
        chk("full_start", dma_start, 1);

        // ---- zero-size descriptor ----
        do_reset();
        ctrl_en = 1'b1; r0 = n_rise; p0 = n_pulse;
        push(8'h50, 8'd0);
        push(8'h60, 8'd1);
        desc_valid = 1'b0;
        wait_idle(300);
        chk("zero_rises", n_rise - r0, 1);
        chk("zero_pulses", n_pulse - p0, 2);
        chk("zero_completed", completed_count, 2);
        chk("zero_mem60", mem[8'h60], 8'h41);
        chk("zero_mem50", mem[8'h50], 8'h00);

        // ---- timeout, halt, err_clear ----
        do_reset();
        ctrl_en = 1'b0; r0 = n_rise;
        push(8'h00, 8'd5);
        push(8'h08, 8'd1);
        desc_valid = 1'b0;
        hi = 0; n = 0;
        while (!timeout_err && n < 100) begin
            if (dma_start) hi++;
            @(negedge clk);
            n++;
        end
        chk("to_err_set", timeout_err, 1);
        chk("to_wait_cycles", hi, 16);
        repeat (5) @(negedge clk);
        chk("halt_no_launch", n_rise - r0, 1);
        chk("halt_qcount", queue_count, 1);
        chk("halt_start", dma_start, 0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        ctrl_en = 1'b1;
        chk("clr_err", timeout_err, 0);
        wait_idle(300);
        chk("clr_completed", completed_count, 1);
        chk("clr_rises", n_rise - r0, 2);
        chk("clr_mem08", mem[8'h08], 8'h41);

        // ---- reset during WAIT_DONE ----
        ctrl_en = 1'b0;
        push(8'h70, 8'd3);
        push(8'h78, 8'd2);
        push(8'h7C, 8'd1);
        desc_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_start_on", dma_start, 1);
        #2 rstn = 1'b0;
        sb.delete();
        #1;
        chk("mid_start_off", dma_start, 0);
        chk("mid_qcount", queue_count, 0);
        chk("mid_completed", completed_count, 0);
        @(negedge clk);
        rstn = 1'b1;
        ctrl_en = 1'b1;
        @(negedge clk);
        push(8'h90, 8'd2);
        desc_valid = 1'b0;
        wait_idle(300);
        chk("post_completed", completed_count, 1);
        chk("post_mem90", mem[8'h90], 8'h41);
        chk("post_mem91", mem[8'h91], 8'h64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_descriptor_scheduler.md
Name: dma_descriptor_scheduler

Overview:
Queues CPU transfer descriptors (start address, byte count) and issues them one at a time to dma_controller_module inside dma_system_top. It drives the controller's start, start_address and transfer_size inputs, and observes its done output. It handles the controller's level-start/level-done handshake, skips zero-length descriptors, and guards each transfer with a timeout. Together these let software post several transfers back-to-back without polling.

Parameters:
ADDR_WIDTH, 8, width of descriptor and DMA start address
SIZE_WIDTH, 8, width of descriptor byte count
QUEUE_DEPTH, 4, descriptor FIFO entries (power of 2, >=2)
TIMEOUT_CYCLES, 1024, max cycles in WAIT_DONE before abort
CNT_WIDTH, 8, width of completed-transfer counter

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
desc_valid  in  1  CPU offers a descriptor this cycle
desc_ready  out  1  queue can accept; push occurs when desc_valid && desc_ready
desc_addr  in  ADDR_WIDTH  descriptor start address
desc_size  in  SIZE_WIDTH  descriptor byte count
dma_start  out  1  to controller start
dma_start_address  out  ADDR_WIDTH  to controller start_address
dma_transfer_size  out  SIZE_WIDTH  to controller transfer_size
dma_done  in  1  from controller done
err_clear  in  1  clears timeout_err and leaves HALT
busy  out  1  state != IDLE or queue non-empty
queue_count  out  $clog2(QUEUE_DEPTH+1)  descriptors queued (excludes the one in flight)
completed_count  out  CNT_WIDTH  transfers finished; wraps modulo 2^CNT_WIDTH
done_pulse  out  1  one-cycle pulse per completed or skipped descriptor
timeout_err  out  1  sticky; set on timeout

Behaviour:
- Reset values: all outputs 0, except desc_ready=1 and queue_count=0. Reset empties the FIFO, zeroes pointers and counters, and sets state IDLE.
- Reset mid-transfer: dma_start drops asynchronously to 0. The controller shares rstn and resets with it.
- FIFO is a circular buffer with wrap-around read/write pointers and an occupancy count.
  - desc_ready = (count != QUEUE_DEPTH). It is registered from count only, never from a same-cycle pop.
  - Push and pop in the same cycle leave count unchanged.
  - A push while full is ignored.
- States: IDLE, LAUNCH, WAIT_DONE, RELEASE, HALT.
- IDLE:
  - If the queue is non-empty, pop the head.
  - Size 0: do not launch. Pulse done_pulse, increment completed_count, stay IDLE; the next pop can occur the following cycle.
  - Size >0: latch address/size into dma_start_address/dma_transfer_size, go LAUNCH.
- LAUNCH:
  - Assert dma_start=1, clear the timeout counter, go WAIT_DONE.
  - Address/size stay stable from LAUNCH until RELEASE exits.
- WAIT_DONE:
  - Hold dma_start=1 and increment the timeout counter each cycle.
  - dma_done=1: go RELEASE and drop dma_start the same clock.
  - Else if counter reaches TIMEOUT_CYCLES-1: set timeout_err, drop dma_start, go HALT.
- RELEASE:
  - dma_start=0. Wait for dma_done=0; the controller clears done once start falls.
  - Then pulse done_pulse, increment completed_count, go IDLE.
  - The controller's minimum per-descriptor overhead from this handshake is 3 cycles plus the transfer itself.
- HALT:
  - dma_start=0; the queue keeps accepting pushes and pops nothing.
  - err_clear=1: clear timeout_err and go IDLE; the aborted descriptor is discarded and not counted.
- err_clear outside HALT has no effect. dma_done outside WAIT_DONE/RELEASE is ignored.
- The timeout counter is $clog2(TIMEOUT_CYCLES) bits, saturating, reset on LAUNCH.

Decomposition:
- Package dma_sched_pkg:
  - state enum (sched_state_t)
  - descriptor struct (addr, size)
  - default width constants shared with dma_system_top
- One sub-module: dma_desc_fifo, a parameterised synchronous FIFO (push/pop/full/empty/count) holding descriptor structs.
- The FSM, counters and timeout stay in the top module.

Test Plan:
- Single descriptor: push addr=0x10, size=4 to a fully connected dma_system_top.
  - dma_start rises 2 cycles after the push.
  - Memory 0x10..0x13 = 0x41,0x64,0x76,0x61.
  - done_pulse fires once; completed_count=1.
- Back-to-back queue: push (0x20,2), (0x30,3), (0x40,1) on consecutive cycles.
  - queue_count peaks at 2 or 3.
  - Memory 0x20=0x6E,0x21=0x63; 0x30=0x65,0x31=0x64,0x32=0x20; 0x40=0x44.
  - completed_count=3; dma_start falls between each transfer.
- Full queue: with dma_done tied 0, push 6 descriptors.
  - The first is popped; the remaining 4 fill the FIFO and desc_ready=0.
  - The 6th is ignored; queue_count=4.
- Zero size: push (0x50,0) then (0x60,1).
  - No dma_start for the first; done_pulse fires for it.
  - The second transfers 1 byte to 0x60; completed_count=2.
- Timeout: TIMEOUT_CYCLES=16, dma_done held 0, push (0x00,5).
  - timeout_err=1 after 16 WAIT_DONE cycles, then HALT.
  - A queued second descriptor is not launched.
  - err_clear: timeout_err=0, the second descriptor launches, completed_count=1.
- Reset mid-transfer: assert rstn=0 during WAIT_DONE.
  - dma_start=0, queue_count=0 and completed_count=0 immediately.
  - After release, a new push completes normally.
